// File: rtl/sva_rep_seq_monitor_if.sv
// Signal bundle for one bounded-repetition monitor instance.
// master: the SVA front end / harness that drives a, b, c and disable_i and
//         consumes the verdicts and statistics.
// slave:  the monitor itself.
interface sva_rep_seq_monitor_if #(
  parameter int CNT_W = 16
);
  logic             disable_i;
  logic             a;
  logic             b;
  logic             c;
  logic             pass_o;
  logic             fail_o;
  logic             busy_o;
  logic [CNT_W-1:0] attempt_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output disable_i, a, b, c,
    input  pass_o, fail_o, busy_o, attempt_cnt, pass_cnt, fail_cnt
  );

  modport slave (
    input  disable_i, a, b, c,
    output pass_o, fail_o, busy_o, attempt_cnt, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/sva_rep_seq_monitor.sv
// Runtime checker for  a |-> ##1 b[*MIN_REP:MAX_REP] ##1 c.
// Every pending attempt is represented by one bit of an age vector; bit d
// means "launched d cycles ago and has seen d-1 consecutive b cycles".
// Overlapping attempts of the same age are indistinguishable, so one bit per
// age is enough to track all of them.
module sva_rep_seq_monitor #(
  parameter int MIN_REP = 0,
  parameter int MAX_REP = 2,
  parameter int CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  sva_rep_seq_monitor_if.slave mon
);

  localparam int NA = MAX_REP + 1;          // number of ages
  localparam int PW = $clog2(NA + 1);       // width of a popcount over ages

  if (MAX_REP < 0 || MAX_REP > 15 || MIN_REP < 0 || MIN_REP > MAX_REP || CNT_W < 4) begin : g_bad_params
    $error("sva_rep_seq_monitor: illegal MIN_REP/MAX_REP/CNT_W");
  end

  logic [NA:1]      alive_q;
  logic [NA:1]      alive_d;
  logic [NA:1]      hit;
  logic [NA:1]      ext;
  logic [NA:1]      miss;
  logic             launch;
  logic             pass_q;
  logic             fail_q;
  logic [CNT_W-1:0] attempt_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;

  function automatic logic [PW-1:0] popcnt(input logic [NA:1] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 1; i <= NA; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  // Clamp at all-ones instead of wrapping; the sum never exceeds 2x the max.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [PW-1:0]    inc);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W + 1)'(inc);
    if (s[CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Per-age verdict: c wins over b (first match), disable suppresses everything.
  always_comb begin
    hit  = '0;
    ext  = '0;
    miss = '0;
    if (!mon.disable_i) begin
      for (int d = 1; d <= NA; d++) begin
        if (alive_q[d]) begin
          if (mon.c && (d - 1) >= MIN_REP)      hit[d]  = 1'b1;
          else if (mon.b && (d - 1) < MAX_REP)  ext[d]  = 1'b1;
          else                                  miss[d] = 1'b1;
        end
      end
    end
  end

  // Continuing attempts age by one; a new launch enters at age 1.
  always_comb begin
    launch  = mon.a & ~mon.disable_i;
    alive_d = (ext << 1) | NA'(launch);
  end

  // Age vector, verdict pulses and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q    <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      attempt_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      alive_q    <= alive_d;
      pass_q     <= |hit;
      fail_q     <= |miss;
      pass_cnt_q <= sat_add(pass_cnt_q, popcnt(hit));
      fail_cnt_q <= sat_add(fail_cnt_q, popcnt(miss));
      if (launch && attempt_q != '1) attempt_q <= attempt_q + CNT_W'(1);
    end
  end

  assign mon.pass_o      = pass_q;
  assign mon.fail_o      = fail_q;
  assign mon.busy_o      = |alive_q;
  assign mon.attempt_cnt = attempt_q;
  assign mon.pass_cnt    = pass_cnt_q;
  assign mon.fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_sva_rep_seq_monitor.sv
// Bench for sva_rep_seq_monitor: four parameterisations share one stimulus
// stream; u0 (0,2) is checked by a vector table and a random run against an
// attempt-list model, the others by short directed sequences.
module tb_sva_rep_seq_monitor;

  localparam int U0_MIN = 0;
  localparam int U0_MAX = 2;
  localparam int CMAX16 = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, dis = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0;

  sva_rep_seq_monitor_if #(.CNT_W(16)) if0 ();
  sva_rep_seq_monitor_if #(.CNT_W(16)) if1 ();
  sva_rep_seq_monitor_if #(.CNT_W(16)) if2 ();
  sva_rep_seq_monitor_if #(.CNT_W(4))  if3 ();

  assign if0.disable_i = dis; assign if0.a = a; assign if0.b = b; assign if0.c = c;
  assign if1.disable_i = dis; assign if1.a = a; assign if1.b = b; assign if1.c = c;
  assign if2.disable_i = dis; assign if2.a = a; assign if2.b = b; assign if2.c = c;
  assign if3.disable_i = dis; assign if3.a = a; assign if3.b = b; assign if3.c = c;

  sva_rep_seq_monitor #(.MIN_REP(0), .MAX_REP(2), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .mon(if0));
  sva_rep_seq_monitor #(.MIN_REP(0), .MAX_REP(0), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .mon(if1));
  sva_rep_seq_monitor #(.MIN_REP(2), .MAX_REP(3), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .mon(if2));
  sva_rep_seq_monitor #(.MIN_REP(0), .MAX_REP(2), .CNT_W(4))  u3 (.clk(clk), .rst(rst), .mon(if3));

  typedef struct {
    logic r, d, aa, bb, cc;
    logic ep, ef, eb;
    int   eatt, epc, efc;
  } vec_t;

  typedef struct {
    logic p, f, bz;
    int   att, pc, fc;
  } exp_t;

  vec_t tbl[28];
  exp_t sb[$];
  int   mq[$];
  int   m_att, m_pc, m_fc;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int r, d, aa, bb, cc, ep, ef, eb, eatt, epc, efc);
    vec_t v;
    v.r = 1'(r); v.d = 1'(d); v.aa = 1'(aa); v.bb = 1'(bb); v.cc = 1'(cc);
    v.ep = 1'(ep); v.ef = 1'(ef); v.eb = 1'(eb);
    v.eatt = eatt; v.epc = epc; v.efc = efc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, d, aa, bb, cc);
    rst = r; dis = d; a = aa; b = bb; c = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_u0(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty, got no expectation", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".pass_o"},      32'(if0.pass_o),      32'(e.p));
    chk({tag, ".fail_o"},      32'(if0.fail_o),      32'(e.f));
    chk({tag, ".busy_o"},      32'(if0.busy_o),      32'(e.bz));
    chk({tag, ".attempt_cnt"}, 32'(if0.attempt_cnt), e.att);
    chk({tag, ".pass_cnt"},    32'(if0.pass_cnt),    e.pc);
    chk({tag, ".fail_cnt"},    32'(if0.fail_cnt),    e.fc);
  endtask

  // Reference: a list of pending attempts, each holding its b count.
  function automatic exp_t model(input logic r, d, aa, bb, cc);
    exp_t e;
    int   nq[$];
    int   nh, nm;
    nh = 0; nm = 0;
    if (r) begin
      mq.delete(); m_att = 0; m_pc = 0; m_fc = 0;
    end else if (d) begin
      mq.delete();
    end else begin
      foreach (mq[i]) begin
        if (cc && mq[i] >= U0_MIN)      nh++;
        else if (bb && mq[i] < U0_MAX)  nq.push_back(mq[i] + 1);
        else                            nm++;
      end
      if (aa) begin
        nq.push_back(0);
        if (m_att < CMAX16) m_att++;
      end
      mq   = nq;
      m_pc = (m_pc + nh > CMAX16) ? CMAX16 : m_pc + nh;
      m_fc = (m_fc + nm > CMAX16) ? CMAX16 : m_fc + nm;
    end
    e.p = (nh > 0); e.f = (nm > 0); e.bz = (mq.size() > 0);
    e.att = m_att; e.pc = m_pc; e.fc = m_fc;
    return e;
  endfunction

  initial begin
    exp_t e;
    logic r, d, aa, bb, cc;

    //            rst dis a b c   pass fail busy  att pc fc
    tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0,  0, 0, 1,  1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1,  1, 0, 0,  1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0,  0, 0, 1,  2, 1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0,  0, 0, 1,  2, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0,  0, 0, 1,  2, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1,  1, 0, 0,  2, 2, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0,  0, 0, 1,  3, 2, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0,  0, 0, 1,  3, 2, 0);
    tbl[10] = mk(0, 0, 0, 1, 0,  0, 0, 1,  3, 2, 0);
    tbl[11] = mk(0, 0, 0, 1, 0,  0, 1, 0,  3, 2, 1);
    tbl[12] = mk(0, 0, 0, 0, 1,  0, 0, 0,  3, 2, 1);
    tbl[13] = mk(0, 0, 1, 0, 0,  0, 0, 1,  4, 2, 1);
    tbl[14] = mk(0, 0, 1, 1, 0,  0, 0, 1,  5, 2, 1);
    tbl[15] = mk(0, 0, 1, 1, 0,  0, 0, 1,  6, 2, 1);
    tbl[16] = mk(0, 0, 0, 0, 1,  1, 0, 0,  6, 5, 1);
    tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0,  6, 5, 1);
    tbl[18] = mk(0, 0, 1, 0, 0,  0, 0, 1,  7, 5, 1);
    tbl[19] = mk(0, 0, 0, 0, 0,  0, 1, 0,  7, 5, 2);
    tbl[20] = mk(0, 0, 1, 0, 0,  0, 0, 1,  8, 5, 2);
    tbl[21] = mk(0, 0, 1, 1, 0,  0, 0, 1,  9, 5, 2);
    tbl[22] = mk(0, 1, 1, 1, 1,  0, 0, 0,  9, 5, 2);
    tbl[23] = mk(0, 0, 0, 0, 0,  0, 0, 0,  9, 5, 2);
    tbl[24] = mk(0, 0, 1, 0, 0,  0, 0, 1, 10, 5, 2);
    tbl[25] = mk(0, 0, 0, 1, 0,  0, 0, 1, 10, 5, 2);
    tbl[26] = mk(1, 0, 1, 0, 1,  0, 0, 0,  0, 0, 0);
    tbl[27] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      e.p = tbl[i].ep; e.f = tbl[i].ef; e.bz = tbl[i].eb;
      e.att = tbl[i].eatt; e.pc = tbl[i].epc; e.fc = tbl[i].efc;
      sb.push_back(e);
      drv(tbl[i].r, tbl[i].d, tbl[i].aa, tbl[i].bb, tbl[i].cc);
      check_u0($sformatf("tbl[%0d]", i));
    end

    // Exact zero repetition (0,0): b instead of c fails, c right after a passes.
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 1, 0, 0);
    chk("u1.busy_after_a", 32'(if1.busy_o), 32'd1);
    drv(0, 0, 0, 1, 0);
    chk("u1.fail_o", 32'(if1.fail_o), 32'd1);
    chk("u1.pass_o_low", 32'(if1.pass_o), 32'd0);
    chk("u1.busy_o_done", 32'(if1.busy_o), 32'd0);
    chk("u1.fail_cnt", 32'(if1.fail_cnt), 32'd1);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1);
    chk("u1.pass_o", 32'(if1.pass_o), 32'd1);
    chk("u1.pass_cnt", 32'(if1.pass_cnt), 32'd1);
    chk("u1.attempt_cnt", 32'(if1.attempt_cnt), 32'd2);

    // Minimum bound (2,3): under-minimum fail, exact pass, mixed verdicts, over-max fail.
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1);
    chk("u2.under_min.fail_o", 32'(if2.fail_o), 32'd1);
    chk("u2.under_min.pass_o", 32'(if2.pass_o), 32'd0);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1);
    chk("u2.at_min.pass_o", 32'(if2.pass_o), 32'd1);
    chk("u2.at_min.fail_o", 32'(if2.fail_o), 32'd0);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 1, 1, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1);
    chk("u2.mixed.pass_o", 32'(if2.pass_o), 32'd1);
    chk("u2.mixed.fail_o", 32'(if2.fail_o), 32'd1);
    chk("u2.mixed.pass_cnt", 32'(if2.pass_cnt), 32'd2);
    chk("u2.mixed.fail_cnt", 32'(if2.fail_cnt), 32'd2);
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 1, 0);
    chk("u2.at_max.busy_o", 32'(if2.busy_o), 32'd1);
    drv(0, 0, 0, 1, 0);
    chk("u2.over_max.fail_o", 32'(if2.fail_o), 32'd1);
    chk("u2.over_max.fail_cnt", 32'(if2.fail_cnt), 32'd3);
    chk("u2.over_max.busy_o", 32'(if2.busy_o), 32'd0);

    // Saturation with CNT_W=4: 20 passing attempts clamp at 15.
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drv(0, 0, 1, 0, 0);
      drv(0, 0, 0, 0, 1);
      if (i == 13) chk("u3.pass_cnt_14", 32'(if3.pass_cnt), 32'd14);
    end
    chk("u3.pass_cnt_sat", 32'(if3.pass_cnt), 32'd15);
    chk("u3.attempt_cnt_sat", 32'(if3.attempt_cnt), 32'd15);
    chk("u3.fail_cnt", 32'(if3.fail_cnt), 32'd0);
    chk("u3.pass_o", 32'(if3.pass_o), 32'd1);

    // Random traffic on u0 against the attempt-list model.
    for (int i = 0; i < 400; i++) begin
      r  = (i == 0) || ($urandom_range(99) == 0);
      d  = ($urandom_range(24) == 0);
      aa = ($urandom_range(1) == 0);
      bb = ($urandom_range(2) != 0);
      cc = ($urandom_range(2) == 0);
      sb.push_back(model(r, d, aa, bb, cc));
      drv(r, d, aa, bb, cc);
      check_u0($sformatf("rnd[%0d]", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
